// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: RW registers with byte-lane writes, read-only
// registers sourced from hw_status, per-register write strobes.
module axi_lite_regbank #(
   parameter int unsigned           C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned           C_S_AXI_ADDR_WIDTH = 8,
   parameter int unsigned           C_NUM_REGS         = 8,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
   input  logic                                       S_AXI_ACLK,
   input  logic                                       S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
   input  logic [2:0]                                 S_AXI_AWPROT,
   input  logic                                       S_AXI_AWVALID,
   output logic                                       S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
   input  logic                                       S_AXI_WVALID,
   output logic                                       S_AXI_WREADY,
   output logic [1:0]                                 S_AXI_BRESP,
   output logic                                       S_AXI_BVALID,
   input  logic                                       S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
   input  logic [2:0]                                 S_AXI_ARPROT,
   input  logic                                       S_AXI_ARVALID,
   output logic                                       S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
   output logic [1:0]                                 S_AXI_RRESP,
   output logic                                       S_AXI_RVALID,
   input  logic                                       S_AXI_RREADY,
   output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
   input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_status,
   output logic [C_NUM_REGS-1:0]                      wr_pulse
);

   localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
   localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned SW       = DW / 8;
   localparam int unsigned ADDR_LSB = $clog2(SW);
   localparam int unsigned IDX_W    = $clog2(C_NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Register index field of a byte address (low lane bits dropped)
   function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
      return IDX_W'(a >> ADDR_LSB);
   endfunction

   // Any set bit above the index field means no register lives there
   function automatic logic addr_oor(input logic [AW-1:0] a);
      return (a >> (ADDR_LSB + IDX_W)) != '0;
   endfunction

   logic             out_en;
   logic             aw_held;
   logic             w_held;
   logic [AW-1:0]    aw_addr;
   logic [DW-1:0]    w_data;
   logic [SW-1:0]    w_strb;
   logic [DW-1:0]    regs [C_NUM_REGS];

   logic             aw_hs;
   logic             w_hs;
   logic             ar_hs;
   logic             commit;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             wr_ok;
   logic             rd_oor;
   logic [DW-1:0]    wr_merged;
   logic [DW-1:0]    rd_data_c;
   logic [1:0]       rd_resp_c;
   logic             unused_prot;

   // Protection attributes carry no meaning for this bank
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // Channel readiness is held off until the first edge after reset release
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) out_en <= 1'b0;
      else              out_en <= 1'b1;
   end

   assign S_AXI_AWREADY = out_en && !aw_held && !S_AXI_BVALID;
   assign S_AXI_WREADY  = out_en && !w_held  && !S_AXI_BVALID;
   assign S_AXI_ARREADY = out_en && !S_AXI_RVALID;

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign commit = aw_held && w_held;

   assign wr_idx = addr_idx(aw_addr);
   assign wr_ok  = !addr_oor(aw_addr) && !C_RO_MASK[wr_idx];
   assign rd_idx = addr_idx(S_AXI_ARADDR);
   assign rd_oor = addr_oor(S_AXI_ARADDR);

   // Byte-lane merge of held write data into the addressed register
   always_comb begin
      wr_merged = regs[wr_idx];
      for (int unsigned b = 0; b < SW; b++) begin
         if (w_strb[b]) wr_merged[b*8 +: 8] = w_data[b*8 +: 8];
      end
   end

   // Read data/response selection for the address on the AR channel
   always_comb begin
      rd_data_c = '0;
      rd_resp_c = RESP_OKAY;
      if (rd_oor)                 rd_resp_c = RESP_SLVERR;
      else if (C_RO_MASK[rd_idx]) rd_data_c = hw_status[rd_idx*DW +: DW];
      else                        rd_data_c = regs[rd_idx];
   end

   // Write path: AW/W holding registers, commit, B response and write strobes
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_addr      <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         wr_pulse     <= '0;
      end else begin
         wr_pulse <= '0;
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr <= S_AXI_AWADDR;
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) wr_pulse <= C_NUM_REGS'(1) << wr_idx;
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   // Register storage; only legal RW targets are ever written
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         for (int unsigned i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
      end else if (commit && wr_ok) begin
         regs[wr_idx] <= wr_merged;
      end
   end

   // Read path: capture on AR handshake, hold until R handshake
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_data_c;
         S_AXI_RRESP  <= rd_resp_c;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

   // Flattened RW register view; read-only slots are tied to zero
   for (genvar i = 0; i < int'(C_NUM_REGS); i++) begin : g_reg_out
      assign reg_out[i*DW +: DW] = C_RO_MASK[i] ? '0 : regs[i];
   end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Randomized and directed checking of axi_lite_regbank against a transaction-level model.
module tb_axi_lite_regbank;

   localparam logic [7:0] RO_MASK = 8'h80;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [255:0] reg_out, hw_status;
   logic [7:0]   wr_pulse;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit cmp_en = 1'b0;

   // Model state: register contents plus the one write whose effect is scheduled
   logic [31:0] model_regs [8];
   int          exp_commit_cyc = -1;
   logic [2:0]  exp_commit_idx = 3'd0;
   logic [31:0] exp_commit_val = 32'h0;
   bit          exp_commit_en  = 1'b0;

   axi_lite_regbank #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (8),
      .C_NUM_REGS         (8),
      .C_RO_MASK          (RO_MASK)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_out       (reg_out),
      .hw_status     (hw_status),
      .wr_pulse      (wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycle counter; the scheduled write becomes visible to the model at its cycle
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc == exp_commit_cyc && exp_commit_en) model_regs[exp_commit_idx] = exp_commit_val;
   end

   // Per-cycle comparison of register view and write strobes against the model
   always @(negedge clk) begin : cmp
      logic [7:0] ep;
      if (cmp_en) begin
         ep = (cyc == exp_commit_cyc && exp_commit_en) ? (8'h01 << exp_commit_idx) : 8'h00;
         for (int i = 0; i < 8; i++)
            chk($sformatf("reg_out[%0d]", i), 64'(reg_out[i*32 +: 32]),
                64'(RO_MASK[i] ? 32'h0 : model_regs[i]));
         chk("wr_pulse", 64'(wr_pulse), 64'(ep));
         if (bvalid) begin
            chk("awready_while_bvalid", 64'(awready), 64'(0));
            chk("wready_while_bvalid", 64'(wready), 64'(0));
         end
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 8; i++) model_regs[i] = 32'h0;
      exp_commit_cyc = -1;
      exp_commit_en  = 1'b0;
   endtask

   // One write: AW and W presented after their own delays, B held off for b_dly cycles
   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input bit lit_en, input logic [1:0] lit_resp);
      int aw_hs, w_hs, t;
      logic [2:0]  idx;
      bit          ok;
      logic [1:0]  resp;
      logic [31:0] mrg;
      aw_hs = -1; w_hs = -1; t = 0;
      while ((aw_hs < 0 || w_hs < 0) && t < 100) begin
         if (aw_hs < 0 && t >= aw_dly) begin awaddr = addr; awprot = 3'($urandom); awvalid = 1'b1; end
         if (w_hs < 0 && t >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
         @(negedge clk);
         if (awvalid && awready) aw_hs = cyc;
         if (wvalid && wready)   w_hs  = cyc;
         @(posedge clk); #1;
         if (aw_hs >= 0) awvalid = 1'b0;
         if (w_hs >= 0)  wvalid  = 1'b0;
         t++;
      end
      if (aw_hs < 0 || w_hs < 0) begin
         chk("write_handshake_timeout", 64'(1), 64'(0));
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      idx  = addr[4:2];
      ok   = (addr[7:5] == 3'b000) && !RO_MASK[idx];
      resp = ok ? 2'b00 : 2'b10;
      mrg  = model_regs[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) mrg[b*8 +: 8] = data[b*8 +: 8];
      exp_commit_idx = idx;
      exp_commit_val = mrg;
      exp_commit_en  = ok;
      exp_commit_cyc = ((aw_hs > w_hs) ? aw_hs : w_hs) + 2;
      @(negedge clk);
      chk("bvalid_early", 64'(bvalid), 64'(0));
      @(posedge clk); #1;
      for (int k = 0; k <= b_dly; k++) begin
         bready = (k == b_dly);
         @(negedge clk);
         chk("bvalid", 64'(bvalid), 64'(1));
         chk("bresp", 64'(bresp), 64'(resp));
         if (lit_en) chk("bresp_literal", 64'(bresp), 64'(lit_resp));
         @(posedge clk); #1;
      end
      bready = 1'b0;
      @(negedge clk);
      chk("bvalid_clear", 64'(bvalid), 64'(0));
      @(posedge clk); #1;
   endtask

   // One read: AR after pre_dly cycles, R accepted after r_dly stalled cycles
   task automatic do_read(input logic [7:0] addr, input int pre_dly, input int r_dly,
                          input bit lit_en, input logic [31:0] lit_data, input logic [1:0] lit_resp);
      int t;
      bit hs;
      logic [31:0] ed;
      logic [1:0]  er;
      logic [2:0]  idx;
      repeat (pre_dly) begin @(posedge clk); #1; end
      araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
      hs = 1'b0; t = 0; ed = 32'h0; er = 2'b00;
      while (!hs && t < 100) begin
         @(negedge clk);
         if (arready) begin
            hs  = 1'b1;
            idx = addr[4:2];
            if (addr[7:5] != 3'b000) begin ed = 32'h0; er = 2'b10; end
            else if (RO_MASK[idx])   begin ed = hw_status[idx*32 +: 32]; er = 2'b00; end
            else                     begin ed = model_regs[idx]; er = 2'b00; end
         end
         @(posedge clk); #1;
         t++;
      end
      arvalid = 1'b0;
      if (!hs) begin
         chk("read_handshake_timeout", 64'(1), 64'(0));
         return;
      end
      for (int k = 0; k <= r_dly; k++) begin
         rready = (k == r_dly);
         @(negedge clk);
         chk("rvalid", 64'(rvalid), 64'(1));
         chk("rdata", 64'(rdata), 64'(ed));
         chk("rresp", 64'(rresp), 64'(er));
         if (lit_en) begin
            chk("rdata_literal", 64'(rdata), 64'(lit_data));
            chk("rresp_literal", 64'(rresp), 64'(lit_resp));
         end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      @(negedge clk);
      chk("rvalid_clear", 64'(rvalid), 64'(0));
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, 64'(awready), 64'(0));
      chk({tag, "_wready"},  64'(wready),  64'(0));
      chk({tag, "_arready"}, 64'(arready), 64'(0));
      chk({tag, "_bvalid"},  64'(bvalid),  64'(0));
      chk({tag, "_rvalid"},  64'(rvalid),  64'(0));
      chk({tag, "_bresp"},   64'(bresp),   64'(0));
      chk({tag, "_rresp"},   64'(rresp),   64'(0));
      chk({tag, "_rdata"},   64'(rdata),   64'(0));
   endtask

   function automatic logic [7:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return 8'($urandom_range(32, 255));
      return {3'b000, 3'($urandom), 2'($urandom)};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_model();
      awaddr = 8'h0; araddr = 8'h0; awprot = 3'h0; arprot = 3'h0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = 32'h0; wstrb = 4'h0;
      for (int i = 0; i < 8; i++) hw_status[i*32 +: 32] = $urandom;
      rst = 1'b1;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("awready_after_reset", 64'(awready), 64'(1));
      chk("wready_after_reset",  64'(wready),  64'(1));
      chk("arready_after_reset", 64'(arready), 64'(1));
      @(posedge clk); #1;

      // Sequential writes then read-back of the first four registers
      for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, 1'b1, 2'b00);
      for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0, i, 1'b1, 32'(i + 1), 2'b00);

      // Partial byte-lane write
      do_write(8'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, 1'b1, 2'b00);
      do_write(8'h04, 32'h11223344, 4'b0101, 1, 0, 1, 1'b1, 2'b00);
      do_read(8'h04, 0, 0, 1'b1, 32'hAA22CC44, 2'b00);

      // Empty strobe: OKAY, strobe pulse, no data change
      do_write(8'h04, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 1'b1, 2'b00);
      do_read(8'h05, 0, 0, 1'b1, 32'hAA22CC44, 2'b00);

      // Read-only register
      hw_status[7*32 +: 32] = 32'hCAFEF00D;
      do_write(8'h1C, 32'h0, 4'hF, 0, 0, 0, 1'b1, 2'b10);
      do_read(8'h1C, 0, 0, 1'b1, 32'hCAFEF00D, 2'b00);

      // W three cycles ahead of AW, BREADY held low four cycles
      do_write(8'h18, 32'h600D600D, 4'hF, 3, 0, 4, 1'b1, 2'b00);
      do_read(8'h18, 0, 0, 1'b1, 32'h600D600D, 2'b00);

      // Out-of-range address
      do_read(8'h40, 0, 0, 1'b1, 32'h0, 2'b10);
      do_write(8'h40, 32'h12345678, 4'hF, 0, 2, 0, 1'b1, 2'b10);

      // Read racing a commit to the same register returns the old value
      fork
         do_write(8'h08, 32'h00000055, 4'hF, 0, 0, 0, 1'b1, 2'b00);
         do_read(8'h08, 1, 0, 1'b1, 32'h00000003, 2'b00);
      join
      do_read(8'h08, 0, 0, 1'b1, 32'h00000055, 2'b00);

      // Reset with AW held and W pending
      do_write(8'h14, 32'h12345678, 4'hF, 0, 0, 0, 1'b0, 2'b00);
      awaddr = 8'h14; awvalid = 1'b1;
      @(negedge clk);
      chk("rst_aw_accept", 64'(awready), 64'(1));
      @(posedge clk); #1;
      awvalid = 1'b0; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      rst = 1'b1;
      clear_model();
      repeat (2) begin
         @(negedge clk);
         chk_reset_outputs("midreset");
         @(posedge clk); #1;
      end
      wvalid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      repeat (4) begin
         @(negedge clk);
         chk("bvalid_after_midreset", 64'(bvalid), 64'(0));
         chk("awready_after_midreset", 64'(awready), 64'(1));
         chk("wready_after_midreset", 64'(wready), 64'(1));
         @(posedge clk); #1;
      end
      do_write(8'h14, 32'h0000BEEF, 4'hF, 0, 1, 0, 1'b1, 2'b00);
      do_read(8'h14, 0, 0, 1'b1, 32'h0000BEEF, 2'b00);
      do_read(8'h00, 0, 0, 1'b1, 32'h0, 2'b00);

      // Randomized concurrent reads and writes
      for (int it = 0; it < 60; it++) begin
         logic [7:0] wa, ra;
         if (it % 8 == 0) for (int i = 0; i < 8; i++) hw_status[i*32 +: 32] = $urandom;
         wa = rand_addr();
         ra = rand_addr();
         fork
            do_write(wa, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 2'b00);
            do_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 32'h0, 2'b00);
         join
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
